// File: rtl/cpu_sched_pkg.sv
// Shared types and default constants for the preemptive quantum scheduler.
package cpu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SAVE = 2'd2,
        ST_JUMP = 2'd3
    } sched_state_e;

    localparam int unsigned QUANTUM_W_DEF = 16;
    localparam logic [31:0] OS_ENTRY_DEF  = 32'd0;
    localparam logic [31:0] SAVE_ADDR_DEF = 32'd0;
    localparam int unsigned STATS_W       = 16;

endpackage

// File: rtl/quantum_counter.sv
// Loadable down-counter with zero/one flags; decrement never wraps below zero.
module quantum_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec_en,
    output logic [W-1:0] count,
    output logic         is_zero_c,
    output logic         is_one_c
);

    assign is_zero_c = (count == '0);
    assign is_one_c  = (count == W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec_en && !is_zero_c) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemptive time-slice controller: counts retired user instructions, then saves PC and jumps to the OS.
// Optional feature: define QUANTUM_SCHED_STATS_EN to add the saturating preempt_count output.
module quantum_scheduler
    import cpu_sched_pkg::*;
#(
    parameter int unsigned QUANTUM_W = QUANTUM_W_DEF,
    parameter logic [31:0] OS_ENTRY  = OS_ENTRY_DEF,
    parameter logic [31:0] SAVE_ADDR = SAVE_ADDR_DEF
) (
    input  logic                 clock,
    input  logic                 reseta,
    input  logic                 halt,
    input  logic                 set_quantum,
    input  logic [QUANTUM_W-1:0] quantum_value,
    input  logic                 jump_user,
    input  logic                 user_exit,
    input  logic                 instr_retire,
    input  logic [31:0]          pc,
    output logic                 stall,
    output logic                 mem_write,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_data,
    output logic                 preempt_jump,
    output logic [31:0]          preempt_addr,
    output logic                 user_mode,
    output logic [QUANTUM_W-1:0] remaining
`ifdef QUANTUM_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0]   preempt_count
`endif
);

    sched_state_e         state, next_state;
    logic [QUANTUM_W-1:0] quantum_q;
    logic [QUANTUM_W-1:0] eff_quantum;
    logic                 cnt_load, cnt_dec, cnt_zero, cnt_one;

    assign mem_addr     = SAVE_ADDR;
    assign preempt_addr = OS_ENTRY;

    // A quantum written in the same cycle as the jump takes effect immediately.
    assign eff_quantum = set_quantum ? quantum_value : quantum_q;

    quantum_counter #(.W(QUANTUM_W)) u_counter (
        .clk        (clock),
        .rst_n      (reseta),
        .load       (cnt_load),
        .load_value (eff_quantum),
        .dec_en     (cnt_dec),
        .count      (remaining),
        .is_zero_c  (cnt_zero),
        .is_one_c   (cnt_one)
    );

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (jump_user && (eff_quantum != '0)) begin
                    cnt_load   = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Voluntary exit beats an expiry in the same cycle.
                if (user_exit) begin
                    next_state = ST_IDLE;
                end else if (instr_retire && !halt && !cnt_zero) begin
                    cnt_dec = 1'b1;
                    if (cnt_one) begin
                        next_state = ST_SAVE;
                    end
                end
            end
            ST_SAVE: next_state = ST_JUMP;
            ST_JUMP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State and output flops; outputs are decoded from the next state so they track the state register.
    always_ff @(posedge clock) begin
        if (!reseta) begin
            state        <= ST_IDLE;
            quantum_q    <= '0;
            stall        <= 1'b0;
            mem_write    <= 1'b0;
            preempt_jump <= 1'b0;
            user_mode    <= 1'b0;
            mem_data     <= '0;
        end else begin
            state        <= next_state;
            stall        <= (next_state == ST_SAVE) || (next_state == ST_JUMP);
            mem_write    <= (next_state == ST_SAVE);
            preempt_jump <= (next_state == ST_JUMP);
            user_mode    <= (next_state == ST_RUN);
            if (set_quantum) begin
                quantum_q <= quantum_value;
            end
            if ((state == ST_RUN) && (next_state == ST_SAVE)) begin
                mem_data <= pc;
            end
        end
    end

`ifdef QUANTUM_SCHED_STATS_EN
    always_ff @(posedge clock) begin
        if (!reseta) begin
            preempt_count <= '0;
        end else if ((state == ST_SAVE) && (next_state == ST_JUMP) &&
                     (preempt_count != {STATS_W{1'b1}})) begin
            preempt_count <= preempt_count + STATS_W'(1);
        end
    end
`endif

endmodule
